// File: rtl/uart_tx_buf.sv
// uart_tx_buf: byte FIFO feeding a UART transmitter.
//   A never-stalling write port fills a DEPTH-entry array. A single output
//   register presents bytes on a valid/ready stream (tdata/tvalid/tready).
//   Total capacity is DEPTH+1 bytes. Writes arriving while the array is full
//   are dropped and raise the sticky ovf flag.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   wr_data, wr_en     enqueue byte / strobe
//   ovf_clr            synchronous clear of ovf (and drop_cnt)
//   full, empty, count array occupancy status (output register not counted)
//   ovf                sticky overflow flag
//   tdata, tvalid      byte stream to the transmitter
//   tready             transmitter accepts the presented byte
//   drop_cnt           saturating dropped-write counter, present only when
//                      UART_TX_BUF_DROPCNT_EN is defined
module uart_tx_buf #(
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       wr_data,
  input  logic             wr_en,
  input  logic             ovf_clr,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             ovf,
  output logic [7:0]       tdata,
  output logic             tvalid,
  input  logic             tready
`ifdef UART_TX_BUF_DROPCNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_acc;
  logic             wr_drop;
  logic             load;
  logic [PTR_W:0]   count_nxt;

  // full/empty are registered, so acceptance and loading depend only on
  // state; a pop in the same cycle never rescues a write seen while full.
  assign wr_acc  = wr_en && !full;
  assign wr_drop = wr_en && full;
  assign load    = (!tvalid || tready) && !empty;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, load})
      2'b10:   count_nxt = count + (PTR_W+1)'(1);
      2'b01:   count_nxt = count - (PTR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Array storage carries no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load)   rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == (PTR_W+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Output register: tdata holds its value after the last byte leaves.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tdata  <= 8'hFF;
      tvalid <= 1'b0;
    end else if (load) begin
      tdata  <= mem[rd_ptr];
      tvalid <= 1'b1;
    end else if (tvalid && tready) begin
      tvalid <= 1'b0;
    end
  end

  // A drop coinciding with a clear leaves the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        ovf <= 1'b0;
    else if (wr_drop) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

`ifdef UART_TX_BUF_DROPCNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt <= '0;
    end else if (wr_drop) begin
      if (ovf_clr)                drop_cnt <= 16'd1;
      else if (drop_cnt != '1)    drop_cnt <= drop_cnt + 16'd1;
    end else if (ovf_clr) begin
      drop_cnt <= '0;
    end
  end
`endif

endmodule
